// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display path: segment patterns and digit count.
// Patterns are active-high, bit order g..a (bit 0 = segment a).
package seven_segment_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NUM_SEGS   = 7;

    localparam logic [NUM_SEGS-1:0] SEG_OFF = 7'b111_1111;

    localparam logic [NUM_SEGS-1:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [NUM_SEGS-1:0] seg_active_low(input logic [3:0] hex);
        return ~SEG_PATTERNS[hex];
    endfunction

endpackage

// File: rtl/seven_segment_decoder_hex_to_seg.sv
// Hex digit to active-low segment lines (bit order g..a); purely combinational,
// zero latency, no flow control.
module hex_to_seg
    import seven_segment_pkg::*;
(
    input  logic [3:0]          num_i,
    output logic [NUM_SEGS-1:0] seg_n_o
);

    assign seg_n_o = seg_active_low(num_i);

endmodule

// File: rtl/seven_segment_decoder.sv
// Registered hex-to-seven-segment decoder with one-hot-zero anode select.
// One cycle latency from num/sel to outputs; always accepts input, no backpressure.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            num,
    input  logic [2:0]            sel,
    output logic                  C1,
    output logic                  C2,
    output logic                  C3,
    output logic                  C4,
    output logic                  C5,
    output logic                  C6,
    output logic                  C7,
    output logic [NUM_DIGITS-1:0] anode
);

    logic [NUM_SEGS-1:0]   seg_d;
    logic [NUM_SEGS-1:0]   seg_q;
    logic [NUM_DIGITS-1:0] anode_d;
    logic [NUM_DIGITS-1:0] anode_q;

    hex_to_seg u_hex_to_seg (
        .num_i   (num),
        .seg_n_o (seg_d)
    );

    always_comb begin
        anode_d      = '1;
        anode_d[sel] = 1'b0;
    end

    // Segments and anodes share one register stage so a frame never mixes old and new.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= SEG_OFF;
            anode_q <= '1;
        end else begin
            seg_q   <= seg_d;
            anode_q <= anode_d;
        end
    end

    assign C1    = seg_q[0];
    assign C2    = seg_q[1];
    assign C3    = seg_q[2];
    assign C4    = seg_q[3];
    assign C5    = seg_q[4];
    assign C6    = seg_q[5];
    assign C7    = seg_q[6];
    assign anode = anode_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench: driver pushes model predictions, monitor pops one per clock edge.
module tb_seven_segment_decoder;

    typedef struct packed {
        logic [6:0] c;   // C1 at bit 6 .. C7 at bit 0
        logic [7:0] an;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] num;
    logic [2:0] sel;
    logic       C1, C2, C3, C4, C5, C6, C7;
    logic [7:0] anode;

    exp_t exp_q[$];
    exp_t last_exp;
    bit   have_last;
    int   n_checks;
    int   n_fails;

    string lit_segs [16] = '{
        "abcdef", "bc",    "abdeg",  "abcdg",
        "bcfg",   "acdfg", "acdefg", "abc",
        "abcdefg","abcdfg","abcefg", "cdefg",
        "adef",   "bcdeg", "adefg",  "aefg"
    };

    seven_segment_decoder dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .sel   (sel),
        .C1    (C1),
        .C2    (C2),
        .C3    (C3),
        .C4    (C4),
        .C5    (C5),
        .C6    (C6),
        .C7    (C7),
        .anode (anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a segment's line is low exactly when its letter appears in the lit list.
    function automatic exp_t model(input bit r, input int n, input int s);
        exp_t  e;
        string segs;
        byte   ch;
        bit    found;
        if (r) begin
            e.c  = 7'b111_1111;
            e.an = 8'hFF;
            return e;
        end
        segs = lit_segs[n];
        for (int k = 0; k < 7; k++) begin
            ch    = 8'd97 + 8'(k);
            found = 1'b0;
            for (int i = 0; i < segs.len(); i++)
                if (segs[i] == ch) found = 1'b1;
            e.c[6-k] = found ? 1'b0 : 1'b1;
        end
        e.an = 8'(255 - (1 << s));
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.c  = {C1, C2, C3, C4, C5, C6, C7};
        a.an = anode;
        return a;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got C1..C7=%b anode=%b, want C1..C7=%b anode=%b",
                     name, got.c, got.an, want.c, want.an);
        end
    endtask

    // Drive on the falling edge; outputs must not move until the next rising edge.
    task automatic drive(input bit r, input int n, input int s);
        exp_t e;
        @(negedge clk);
        rst = r;
        num = 4'(n);
        sel = 3'(s);
        e = model(r, n, s);
        exp_q.push_back(e);
        if (have_last) begin
            #1 check("hold_after_input_change", actual(), last_exp);
            #2 check("hold_mid_cycle", actual(), last_exp);
        end
        last_exp  = e;
        have_last = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t want;
            want = exp_q.pop_front();
            check("edge_output", actual(), want);
        end
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        have_last = 1'b0;
        rst = 1'b1;
        num = 4'd8;
        sel = 3'd3;

        // Reset held with num=8/sel=3, then release loads them.
        drive(1, 8, 3);
        drive(1, 8, 3);
        drive(0, 8, 3);

        for (int n = 0; n < 16; n++) drive(0, n, 0);
        for (int s = 0; s < 8; s++) drive(0, 5, s);

        // Latency: 1 -> 7, the hold checks cover the between-edge window.
        drive(0, 1, 0);
        drive(0, 7, 0);

        // Mid-run reset while showing E.
        drive(0, 14, 4);
        drive(1, 14, 4);
        drive(0, 14, 4);

        // Simultaneous num/sel change.
        drive(0, 3, 2);
        drive(0, 12, 6);

        for (int i = 0; i < 200; i++)
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 15), $urandom_range(0, 7));

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
